// File: rtl/counter_checker.sv
// Tracks an upstream 8-bit up-counter: acquires lock after LOCK_CNT good increments,
// flywheels through isolated glitches and counts mismatches while locked.
module counter_checker #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 2,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       count,
  input  logic             enable,
  input  logic             clear_err,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       expected,
  output logic [7:0]       first_bad
);

  localparam int unsigned RunW  = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW = (UNLOCK_CNT < 2) ? 1 : $clog2(UNLOCK_CNT + 1);
  localparam logic [RunW-1:0]  LockCntV   = RunW'(LOCK_CNT);
  localparam logic [MissW-1:0] UnlockCntV = MissW'(UNLOCK_CNT);

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

  state_e             state_q, state_d;
  logic [RunW-1:0]    run_q, run_d;
  logic [MissW-1:0]   miss_q, miss_d;
  logic [7:0]         exp_q, exp_d;
  logic               mm_q, mm_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [7:0]         fb_q, fb_d;
  logic               fb_vld_q, fb_vld_d;

  logic [RunW-1:0]    run_inc;
  logic [MissW-1:0]   miss_inc;
  logic [ERR_W-1:0]   err_inc;

  always_comb begin
    run_inc  = run_q + RunW'(1);
    miss_inc = miss_q + MissW'(1);
    err_inc  = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);

    state_d  = state_q;
    run_d    = run_q;
    miss_d   = miss_q;
    exp_d    = exp_q;
    mm_d     = 1'b0;
    err_d    = err_q;
    fb_d     = fb_q;
    fb_vld_d = fb_vld_q;

    if (!enable) begin
      state_d = StSearch;
      run_d   = '0;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        StSearch: begin
          exp_d   = count + 8'd1;
          run_d   = '0;
          state_d = StAcquire;
        end
        StAcquire: begin
          // Resynchronise to the observed value on every sample until locked.
          exp_d = count + 8'd1;
          if (count == exp_q) begin
            run_d = run_inc;
            if (run_inc == LockCntV) begin
              state_d = StLocked;
              miss_d  = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        StLocked: begin
          // Flywheel: prediction advances regardless of what was observed.
          exp_d = exp_q + 8'd1;
          if (count == exp_q) begin
            miss_d = '0;
          end else begin
            mm_d   = 1'b1;
            err_d  = err_inc;
            miss_d = miss_inc;
            if (!fb_vld_q) begin
              fb_d     = count;
              fb_vld_d = 1'b1;
            end
            if (miss_inc == UnlockCntV) begin
              state_d = StSearch;
              miss_d  = '0;
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end

    if (clear_err) begin
      err_d    = '0;
      fb_d     = 8'h00;
      fb_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StSearch;
      run_q    <= '0;
      miss_q   <= '0;
      exp_q    <= 8'h00;
      mm_q     <= 1'b0;
      err_q    <= '0;
      fb_q     <= 8'h00;
      fb_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      exp_q    <= exp_d;
      mm_q     <= mm_d;
      err_q    <= err_d;
      fb_q     <= fb_d;
      fb_vld_q <= fb_vld_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign mismatch  = mm_q;
  assign err_count = err_q;
  assign expected  = exp_q;
  assign first_bad = fb_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed-vector bench for counter_checker: default-parameter instance plus an
// ERR_W=2 instance sharing the same stimulus for the saturation case.
module tb_counter_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] count = 8'h00;

  logic        locked, mismatch;
  logic [15:0] err_count;
  logic [7:0]  expected, first_bad;

  logic        locked2, mismatch2;
  logic [1:0]  err_count2;
  logic [7:0]  expected2, first_bad2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_checker dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .enable    (enable),
    .clear_err (clear_err),
    .locked    (locked),
    .mismatch  (mismatch),
    .err_count (err_count),
    .expected  (expected),
    .first_bad (first_bad)
  );

  counter_checker #(.ERR_W(2)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .enable    (enable),
    .clear_err (clear_err),
    .locked    (locked2),
    .mismatch  (mismatch2),
    .err_count (err_count2),
    .expected  (expected2),
    .first_bad (first_bad2)
  );

  typedef struct {
    logic        rst, en, clr;
    logic [7:0]  cnt;
    logic        lk, mm;
    logic [15:0] err;
    logic [7:0]  ex, fb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic en, logic clr, logic [7:0] cnt,
                              logic lk, logic mm, logic [15:0] err,
                              logic [7:0] ex, logic [7:0] fb);
    vec_t v;
    v.rst = rst; v.en = en; v.clr = clr; v.cnt = cnt;
    v.lk = lk; v.mm = mm; v.err = err; v.ex = ex; v.fb = fb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Apply inputs on the falling edge, then sample just after the rising edge.
  task automatic drive(input logic r, input logic e, input logic c, input logic [7:0] cn);
    @(negedge clk);
    reset = r; enable = e; clear_err = c; count = cn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e;

    // Reset, plain lock
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h0A, 0, 0, 0, 8'h0B, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h0B, 0, 0, 0, 8'h0C, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h0C, 0, 0, 0, 8'h0D, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h0D, 0, 0, 0, 8'h0E, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h0E, 1, 0, 0, 8'h0F, 8'h00));
    // Enable drop, then lock near the top and wrap through FF->00
    vecs.push_back(mk(0, 0, 0, 8'h55, 0, 0, 0, 8'h0F, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'hF9, 0, 0, 0, 8'hFA, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'hFA, 0, 0, 0, 8'hFB, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'hFB, 0, 0, 0, 8'hFC, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'hFC, 0, 0, 0, 8'hFD, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'hFD, 1, 0, 0, 8'hFE, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'hFE, 1, 0, 0, 8'hFF, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'hFF, 1, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 8'h01, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h01, 1, 0, 0, 8'h02, 8'h00));
    // ACQUIRE miss: run restarts, no pulse, expected resyncs
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h02, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h0A, 0, 0, 0, 8'h0B, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h0B, 0, 0, 0, 8'h0C, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h20, 0, 0, 0, 8'h21, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h21, 0, 0, 0, 8'h22, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h22, 0, 0, 0, 8'h23, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h23, 0, 0, 0, 8'h24, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h24, 1, 0, 0, 8'h25, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h25, 1, 0, 0, 8'h26, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h26, 1, 0, 0, 8'h27, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h27, 1, 0, 0, 8'h28, 8'h00));
    // Single glitch while expecting 40
    vecs.push_back(mk(0, 1, 0, 8'd40, 1, 0, 0, 8'h29, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'd99, 1, 1, 1, 8'h2A, 8'd99));
    vecs.push_back(mk(0, 1, 0, 8'd42, 1, 0, 1, 8'h2B, 8'd99));
    for (int k = 8'h2B; k <= 8'h30; k++)
      vecs.push_back(mk(0, 1, 0, 8'(k), 1, 0, 1, 8'(k + 1), 8'd99));
    // Clear on a good sample, then loss of lock while expecting 50
    vecs.push_back(mk(0, 1, 1, 8'h31, 1, 0, 0, 8'd50, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'd7, 1, 1, 1, 8'd51, 8'd7));
    vecs.push_back(mk(0, 1, 0, 8'd7, 0, 1, 2, 8'd52, 8'd7));
    vecs.push_back(mk(0, 1, 0, 8'd8, 0, 0, 2, 8'd9, 8'd7));
    // Reset overrides enable; relock needs LOCK_CNT+1 samples
    vecs.push_back(mk(1, 1, 0, 8'h09, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h10, 0, 0, 0, 8'h11, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h11, 0, 0, 0, 8'h12, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h12, 0, 0, 0, 8'h13, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h13, 0, 0, 0, 8'h14, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'h14, 1, 0, 0, 8'h15, 8'h00));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].cnt);
      chk($sformatf("row%0d locked", i), 32'(locked), 32'(vecs[i].lk));
      chk($sformatf("row%0d mismatch", i), 32'(mismatch), 32'(vecs[i].mm));
      chk($sformatf("row%0d err_count", i), 32'(err_count), 32'(vecs[i].err));
      chk($sformatf("row%0d expected", i), 32'(expected), 32'(vecs[i].ex));
      chk($sformatf("row%0d first_bad", i), 32'(first_bad), 32'(vecs[i].fb));
    end

    // Reset mid-LOCKED with five accumulated errors
    drive(1, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) drive(0, 1, 0, 8'(8'h80 + k));
    chk("midrst lock", 32'(locked), 32'd1);
    e = 8'h85;
    for (int k = 0; k < 9; k++) begin
      drive(0, 1, 0, (k % 2 == 0) ? e + 8'h40 : e);
      e = e + 8'd1;
    end
    chk("midrst err5", 32'(err_count), 32'd5);
    chk("midrst locked", 32'(locked), 32'd1);
    chk("midrst pulse", 32'(mismatch), 32'd1);
    chk("midrst fb", 32'(first_bad), 32'hC5);
    drive(1, 1, 1, e);
    chk("rst locked", 32'(locked), 32'd0);
    chk("rst mismatch", 32'(mismatch), 32'd0);
    chk("rst err", 32'(err_count), 32'd0);
    chk("rst expected", 32'(expected), 32'd0);
    chk("rst first_bad", 32'(first_bad), 32'd0);

    // Saturation at ERR_W=2, then clear coincident with a new mismatch
    for (int k = 0; k < 5; k++) drive(0, 1, 0, 8'(8'h80 + k));
    chk("sat lock", 32'(locked2), 32'd1);
    e = 8'h85;
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 0, (k % 2 == 0) ? e + 8'h40 : e);
      if (k == 0) chk("sat fb", 32'(first_bad2), 32'hC5);
      if (k == 1) chk("sat no double pulse", 32'(mismatch2), 32'd0);
      if (k == 6) begin
        chk("sat err3", 32'(err_count2), 32'd3);
        chk("sat pulse", 32'(mismatch2), 32'd1);
        chk("sat locked", 32'(locked2), 32'd1);
      end
      e = e + 8'd1;
    end
    drive(0, 1, 1, e + 8'h40);
    chk("clr err", 32'(err_count2), 32'd0);
    chk("clr pulse", 32'(mismatch2), 32'd1);
    chk("clr fb", 32'(first_bad2), 32'd0);
    chk("clr err wide", 32'(err_count), 32'd0);
    drive(0, 1, 0, e + 8'd1);
    chk("post clr pulse", 32'(mismatch2), 32'd0);
    chk("post clr expected", 32'(expected2), 32'(8'(e + 8'd2)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
